// File: rtl/deglitch_scan_controller.sv
// deglitch_scan_controller
// Time-multiplexed bipolar deglitch filter. A prescaler tick starts a scan that
// visits one channel per cycle through a single shared compare/count datapath.
// Output flips are recorded as per-channel pending events and drained through
// a valid/ready event port.
//
// Handshake: event_valid/event_channel/event_level are derived only from
// registers. An event is consumed at the rising edge of clk on which
// event_valid and event_ready are both high. The producer never withdraws a
// presented event. A consumer may hold event_ready high permanently.
module deglitch_scan_controller #(
    parameter int CHANNELS        = 8,
    parameter int COUNTER_WIDTH   = 8,
    parameter int PRESCALER_WIDTH = 16,
    parameter logic DEFAULT_OUTPUT = 1'b0,
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       reset,
    input  logic                       clk,
    input  logic                       enable,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_period,
    input  logic [COUNTER_WIDTH-1:0]   delay,
    input  logic [CHANNELS-1:0]        in,
    output logic [CHANNELS-1:0]        out,
    output logic                       event_valid,
    output logic [IDX_W-1:0]           event_channel,
    output logic                       event_level,
    input  logic                       event_ready,
    output logic                       overrun,
    input  logic                       overrun_clear
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           index_q, index_d;
    logic [PRESCALER_WIDTH-1:0] presc_q;
    logic                       tick;
    logic                       scan_active;

    logic [CHANNELS-1:0]        out_q;
    logic [CHANNELS-1:0]        pending_q;
    logic [COUNTER_WIDTH-1:0]   cnt_q [CHANNELS];
    logic                       overrun_q;

    logic                       cur_in;
    logic                       cur_out;
    logic [COUNTER_WIDTH-1:0]   cur_cnt;
    logic                       differ;
    logic                       flip;
    logic [COUNTER_WIDTH-1:0]   cnt_inc;
    logic [IDX_W-1:0]           ev_ch;
    logic                       handshake;

    // Tick fires in the enabled cycle where the prescaler reaches its period.
    always_comb begin
        tick        = enable && (presc_q == prescaler_period);
        scan_active = (state_q == SCAN);
    end

    // Prescaler counts enabled cycles and holds its value while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (enable) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // Scan FSM next state: start on tick, walk every channel, abort on disable.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    index_d = '0;
                end
            end
            SCAN: begin
                if (!enable || (index_q == IDX_W'(CHANNELS - 1))) begin
                    state_d = IDLE;
                    index_d = '0;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    // Scan FSM state and channel index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // Sticky overrun: a tick during a scan is dropped; setting beats clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (tick && scan_active) begin
            overrun_q <= 1'b1;
        end else if (overrun_clear) begin
            overrun_q <= 1'b0;
        end
    end

    // Shared evaluation datapath for the channel selected by the scan index.
    always_comb begin
        cur_in  = in[index_q];
        cur_out = out_q[index_q];
        cur_cnt = cnt_q[index_q];
        differ  = (cur_in != cur_out);
        flip    = scan_active && differ && (cur_cnt >= delay);
        cnt_inc = (cur_cnt == {COUNTER_WIDTH{1'b1}}) ? cur_cnt : cur_cnt + 1'b1;
    end

    // Lowest-index pending channel drives the event port.
    always_comb begin
        ev_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                ev_ch = IDX_W'(i);
            end
        end
        handshake = (|pending_q) && event_ready;
    end

    // Per-channel filter state; an evaluation setting pending overrides the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= {CHANNELS{DEFAULT_OUTPUT}};
            pending_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (handshake) begin
                pending_q[ev_ch] <= 1'b0;
            end
            if (scan_active) begin
                if (!differ) begin
                    cnt_q[index_q] <= '0;
                end else if (flip) begin
                    out_q[index_q]     <= cur_in;
                    cnt_q[index_q]     <= '0;
                    pending_q[index_q] <= 1'b1;
                end else begin
                    cnt_q[index_q] <= cnt_inc;
                end
            end
        end
    end

    assign out           = out_q;
    assign event_valid   = |pending_q;
    assign event_channel = ev_ch;
    assign event_level   = out_q[ev_ch];
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_deglitch_scan_controller.sv
// Self-checking bench for deglitch_scan_controller with a behavioural model.
module tb_deglitch_scan_controller;

    localparam int CH  = 8;
    localparam int CW  = 8;
    localparam int PW  = 16;
    localparam int IW  = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    always #5 clk = ~clk;

    logic          enable = 1'b0;
    logic [PW-1:0] prescaler_period = '0;
    logic [CW-1:0] delay = '0;
    logic [CH-1:0] in = '0;
    logic [CH-1:0] out;
    logic          event_valid;
    logic [IW-1:0] event_channel;
    logic          event_level;
    logic          event_ready = 1'b0;
    logic          overrun;
    logic          overrun_clear = 1'b0;

    deglitch_scan_controller #(
        .CHANNELS(CH), .COUNTER_WIDTH(CW), .PRESCALER_WIDTH(PW), .DEFAULT_OUTPUT(1'b0)
    ) dut (
        .reset(reset), .clk(clk), .enable(enable),
        .prescaler_period(prescaler_period), .delay(delay), .in(in), .out(out),
        .event_valid(event_valid), .event_channel(event_channel),
        .event_level(event_level), .event_ready(event_ready),
        .overrun(overrun), .overrun_clear(overrun_clear)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Model keeps the filter as plain integers: a cycle count into the scan
    // period, the channel currently being visited (-1 when no scan runs), and
    // per-channel level / run-length / pending flag.
    bit m_out  [CH];
    int m_run  [CH];
    bit m_pend [CH];
    int m_pc;
    int m_scan;
    bit m_ovr;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_out[i] = 1'b0; m_run[i] = 0; m_pend[i] = 1'b0;
        end
        m_pc = 0; m_scan = -1; m_ovr = 1'b0;
    endtask

    function automatic int model_first_pending();
        for (int i = 0; i < CH; i++) if (m_pend[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input bit en, input bit rdy, input bit clr,
                              input logic [CH-1:0] in_v, input int period, input int dly);
        bit tick;
        int first;
        tick = en && (m_pc == period);
        if (en) m_pc = tick ? 0 : m_pc + 1;
        first = model_first_pending();
        if (rdy && first >= 0) m_pend[first] = 1'b0;
        if (m_scan >= 0) begin
            if (in_v[m_scan] == m_out[m_scan]) begin
                m_run[m_scan] = 0;
            end else if (m_run[m_scan] >= dly) begin
                m_out[m_scan]  = in_v[m_scan];
                m_run[m_scan]  = 0;
                m_pend[m_scan] = 1'b1;
            end else if (m_run[m_scan] < (1 << CW) - 1) begin
                m_run[m_scan] = m_run[m_scan] + 1;
            end
        end
        if (tick && m_scan >= 0) m_ovr = 1'b1;
        else if (clr)            m_ovr = 1'b0;
        if (m_scan >= 0) m_scan = (!en || m_scan == CH - 1) ? -1 : m_scan + 1;
        else if (tick)   m_scan = 0;
    endtask

    task automatic compare_outputs();
        logic [CH-1:0] exp_out;
        int first;
        for (int i = 0; i < CH; i++) exp_out[i] = m_out[i];
        first = model_first_pending();
        check_eq("out", out, exp_out);
        check_eq("event_valid", event_valid, (first >= 0));
        check_eq("overrun", overrun, m_ovr);
        if (first >= 0) begin
            check_eq("event_channel", event_channel, first);
            check_eq("event_level", event_level, m_out[first]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Each call starts and ends at a falling edge; inputs change only there.
    task automatic run_phase(input int cycles, input int en_pct, input int rdy_pct,
                             input int flip_pct, input int clr_pct);
        for (int c = 0; c < cycles; c++) begin
            compare_outputs();
            enable        = ($urandom_range(0, 99) < en_pct);
            event_ready   = ($urandom_range(0, 99) < rdy_pct);
            overrun_clear = ($urandom_range(0, 99) < clr_pct);
            if ($urandom_range(0, 99) < flip_pct) in[$urandom_range(0, CH - 1)] ^= 1'b1;
            model_step(enable, event_ready, overrun_clear, in, int'(prescaler_period), int'(delay));
            @(negedge clk);
        end
    endtask

    // Asynchronous reset asserted between clock edges and checked before any edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_out", out, '0);
        check_eq("rst_event_valid", event_valid, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        enable = 1'b0; event_ready = 1'b0; overrun_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("init_out", out, '0);
        check_eq("init_event_valid", event_valid, 1'b0);
        check_eq("init_overrun", overrun, 1'b0);
        reset = 1'b0;

        // Steady high on channel 3 must pass after three scans.
        prescaler_period = 16'd9; delay = 8'd2; in = 8'h08;
        run_phase(60, 100, 0, 0, 0);
        check_eq("ch3_rise", out[3], 1'b1);
        check_eq("ch3_event_ch", event_channel, 3);
        run_phase(6, 100, 100, 0, 0);
        check_eq("ch3_acked", event_valid, 1'b0);

        // Two-scan glitch on channel 5 must be rejected.
        do_reset();
        prescaler_period = 16'd9; delay = 8'd2; in = 8'h00;
        run_phase(5, 100, 0, 0, 0);
        in[5] = 1'b1;
        run_phase(20, 100, 0, 0, 0);
        in[5] = 1'b0;
        run_phase(40, 100, 0, 0, 0);
        check_eq("glitch_out5", out[5], 1'b0);
        check_eq("glitch_no_event", event_valid, 1'b0);

        // Channels 1 and 6 flip together with delay 0; drain in order.
        do_reset();
        prescaler_period = 16'd9; delay = 8'd0; in = 8'h42;
        run_phase(25, 100, 0, 0, 0);
        check_eq("dual_first", event_channel, 1);
        run_phase(30, 100, 50, 30, 0);

        // Short period forces overruns; random clears exercise set-vs-clear.
        do_reset();
        prescaler_period = 16'd3; delay = 8'd1; in = 8'h00;
        run_phase(20, 100, 50, 10, 0);
        check_eq("overrun_set", overrun, 1'b1);
        run_phase(200, 100, 50, 10, 15);

        // Enable toggling aborts scans mid-way with delay 0.
        do_reset();
        prescaler_period = 16'd9; delay = 8'd0; in = 8'h00;
        run_phase(400, 80, 40, 20, 5);

        // Fully randomized settings.
        for (int p = 0; p < 6; p++) begin
            do_reset();
            prescaler_period = PW'($urandom_range(0, 12));
            delay = CW'($urandom_range(0, 4));
            in = CH'($urandom);
            run_phase(300, 90, 50, 15, 5);
            delay = CW'($urandom_range(0, 4));
            run_phase(100, 90, 50, 15, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
